// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : shared constants for the CPU core pipeline stage registers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FLD_CTRL    = 0;
  localparam int FLD_PC_NEXT = 1;
  localparam int FLD_ALU     = 2;
  localparam int FLD_DATA2   = 3;
  localparam int FLD_INSTR   = 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_BUSY  = ST_BUSY,
    S_FULL  = ST_FULL
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
//------------------------------------------------------------------------------
// pipe_entry_reg : multi-field word register with load enable and NOP inject
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_entry_reg
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_FIELDS  = 5,
  parameter int                    INSTR_FIELD = FLD_INSTR,
  parameter logic [DATA_WIDTH-1:0] NOP_VAL     = NOP_INSTR
) (
  input  logic                               clk,
  input  logic                               i_rst_n,
  input  logic                               i_load,
  input  logic                               i_nop,
  input  logic [DATA_WIDTH*NUM_FIELDS-1:0]   i_d,
  output logic [DATA_WIDTH*NUM_FIELDS-1:0]   o_q
);

  localparam int             c_W       = DATA_WIDTH * NUM_FIELDS;
  localparam logic [c_W-1:0] c_RST_VAL = c_W'(NOP_VAL) << (INSTR_FIELD * DATA_WIDTH);

  logic [c_W-1:0] r_q;

  // NOP inject only rewrites the instruction field; the other fields keep their value.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= c_RST_VAL;
    end else if (i_nop) begin
      r_q[INSTR_FIELD*DATA_WIDTH +: DATA_WIDTH] <= NOP_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// pipe_stage_reg : valid/ready pipeline stage with 2-entry skid buffer and flush
// Optional macro PIPE_STAGE_STATS_EN adds the o_stall_cnt output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_FIELDS  = 5,
  parameter int                    INSTR_FIELD = FLD_INSTR,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic [DATA_WIDTH*NUM_FIELDS-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH*NUM_FIELDS-1:0] o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]                      o_stall_cnt,
`endif
  input  logic                             i_flush
);

  localparam int c_W = DATA_WIDTH * NUM_FIELDS;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_valid;
  logic           w_ready;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_main_load;
  logic           w_main_from_skid;
  logic           w_skid_load;
  logic [c_W-1:0] w_main_d;
  logic [c_W-1:0] w_main_q;
  logic [c_W-1:0] w_skid_q;

  // Handshake outputs depend on registered state only.
  assign w_valid    = (r_state != S_EMPTY);
  assign w_ready    = (r_state != S_FULL);
  assign w_in_fire  = i_valid & w_ready;
  assign w_out_fire = w_valid & i_ready;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_BUSY;
            w_main_load = 1'b1;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = S_BUSY;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : i_data;

  pipe_entry_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_FIELDS  (NUM_FIELDS),
    .INSTR_FIELD (INSTR_FIELD),
    .NOP_VAL     (NOP_INSTR)
  ) u_main (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_main_load),
    .i_nop   (i_flush),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_entry_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_FIELDS  (NUM_FIELDS),
    .INSTR_FIELD (INSTR_FIELD),
    .NOP_VAL     (NOP_INSTR)
  ) u_skid (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_skid_load),
    .i_nop   (1'b0),
    .i_d     (i_data),
    .o_q     (w_skid_q)
  );

  assign o_data  = w_main_q;
  assign o_valid = w_valid;
  assign o_ready = w_ready;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;

  // Flush does not clear the statistic; only reset does.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (w_valid && !i_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//------------------------------------------------------------------------------
// tb_pipe_stage_reg : self-checking bench with a queue-based reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;

  localparam int          DW   = 32;
  localparam int          NF   = 5;
  localparam int          IFLD = 4;
  localparam int          W    = DW * NF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic [W-1:0] din    = '0;
  logic         vin    = 1'b0;
  logic         rdy_in = 1'b0;
  logic         flush  = 1'b0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]  o_stall_cnt;
`endif

  pipe_stage_reg dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_data      (din),
    .i_valid     (vin),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (rdy_in),
`ifdef PIPE_STAGE_STATS_EN
    .o_stall_cnt (o_stall_cnt),
`endif
    .i_flush     (flush)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: FIFO of accepted words (capacity 2) plus the word on display.
  logic [W-1:0] q[$];
  logic [W-1:0] disp;
  logic [31:0]  exp_stall;

  function automatic logic [W-1:0] nopify(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    r[IFLD*DW +: DW] = NOP;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int f = 0; f < NF; f++) r[f*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    disp      = nopify('0);
    exp_stall = 32'd0;
  endtask

  task automatic model_edge();
    bit vld, in_f, out_f;
    vld = (q.size() > 0);
    if (vld && !rdy_in && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    if (flush) begin
      if (vld) disp = q[0];
      disp = nopify(disp);
      q.delete();
    end else begin
      in_f  = vin && (q.size() < 2);
      out_f = vld && rdy_in;
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(din);
      if (q.size() > 0) disp = q[0];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    vectors++;
    if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    vectors++;
    if (o_data[IFLD*DW +: DW] !== NOP) begin
      miscompares++; $display("FAIL reset_instr got=%h exp=%h", o_data[IFLD*DW +: DW], NOP);
    end
    vectors++;
    if (o_data !== disp) begin miscompares++; $display("FAIL reset_data got=%h exp=%h", o_data, disp); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    int nvalid = 0;
    vin = 1'b1; rdy_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din = rand_word();
      din[DW-1:0] = k;
      step();
      if (o_valid === 1'b1) nvalid++;
      vectors++;
      if (o_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, o_ready); end
      vectors++;
      if (o_data[DW-1:0] !== DW'(k) || o_data !== disp) begin
        miscompares++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, o_data, disp);
      end
    end
    vin = 1'b0;
    step();
    vectors++;
    if (nvalid != 8 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL stream_valid_count got=%0d/%b exp=8/0", nvalid, o_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    a = rand_word(); b = rand_word();
    rdy_in = 1'b0; vin = 1'b1;
    din = a; step();
    din = b; step();
    vin = 1'b0; step();
    vectors++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_full got ready=%b valid=%b exp ready=0 valid=1", o_ready, o_valid);
    end
    vectors++;
    if (o_data !== a) begin miscompares++; $display("FAIL bp_hold_a got=%h exp=%h", o_data, a); end
    rdy_in = 1'b1;
    step();
    vectors++;
    if (o_valid !== 1'b1 || o_data !== b) begin
      miscompares++; $display("FAIL bp_then_b got=%b/%h exp=1/%h", o_valid, o_data, b);
    end
    step();
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained got=%b exp=0", o_valid); end
  endtask

  task automatic test_flush();
    rdy_in = 1'b0; vin = 1'b1;
    din = rand_word(); step();
    din = rand_word(); step();
    vectors++;
    if (o_ready !== 1'b0) begin miscompares++; $display("FAIL flush_prefull got=%b exp=0", o_ready); end
    din = rand_word(); flush = 1'b1;
    step();
    flush = 1'b0; vin = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_state got valid=%b ready=%b exp 0/1", o_valid, o_ready);
    end
    vectors++;
    if (o_data[IFLD*DW +: DW] !== NOP || o_data !== disp) begin
      miscompares++; $display("FAIL flush_data got=%h exp=%h", o_data, disp);
    end
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_deliver i=%0d got=%b exp=0", i, o_valid); end
    end
  endtask

  task automatic test_reset_mid();
    rdy_in = 1'b0; vin = 1'b1;
    din = rand_word(); step();
    din = rand_word(); step();
    vin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== disp) begin
      miscompares++;
      $display("FAIL reset_mid got valid=%b ready=%b data=%h exp 0/1/%h", o_valid, o_ready, o_data, disp);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_in = 1'b0; vin = 1'b1; din = rand_word();
    step();
    vin = 1'b0;
    repeat (7) step();
    vectors++;
    if (o_stall_cnt !== 32'd7) begin miscompares++; $display("FAIL stats_seven got=%0d exp=7", o_stall_cnt); end
    flush = 1'b1; rdy_in = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (o_stall_cnt !== 32'd7) begin miscompares++; $display("FAIL stats_flush got=%0d exp=7", o_stall_cnt); end
    #2 rst_n = 1'b0;
    #1 model_reset();
    vectors++;
    if (o_stall_cnt !== 32'd0) begin miscompares++; $display("FAIL stats_reset got=%0d exp=0", o_stall_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
`endif

  task automatic test_random();
    logic r_s, v_s;
    for (int n = 0; n < 10000; n++) begin
      vin    = ($urandom_range(0, 3) != 0);
      rdy_in = $urandom_range(0, 1) == 1;
      flush  = ($urandom_range(0, 31) == 0);
      din    = rand_word();
      // Wiggle the inputs mid-cycle: the handshake outputs must not follow them.
      r_s = o_ready; v_s = o_valid;
      rdy_in = ~rdy_in; vin = ~vin;
      #1;
      vectors++;
      if (o_ready !== r_s || o_valid !== v_s) begin
        miscompares++;
        $display("FAIL rand_comb_path n=%0d got ready=%b valid=%b exp %b/%b", n, o_ready, o_valid, r_s, v_s);
      end
      rdy_in = ~rdy_in; vin = ~vin;
      step();
      vectors++;
      if (o_valid !== (q.size() > 0) || o_ready !== (q.size() < 2)) begin
        miscompares++;
        $display("FAIL rand_hs n=%0d got valid=%b ready=%b exp occupancy=%0d", n, o_valid, o_ready, q.size());
      end
      vectors++;
      if (o_data !== disp) begin miscompares++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, o_data, disp); end
`ifdef PIPE_STAGE_STATS_EN
      vectors++;
      if (o_stall_cnt !== exp_stall) begin
        miscompares++; $display("FAIL rand_stall n=%0d got=%0d exp=%0d", n, o_stall_cnt, exp_stall);
      end
`endif
    end
    flush = 1'b0; vin = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
